masked_fill_fp16: RTL and testbench
===================================

# masked_fill_fp16

Row-wise hole filler for the dfdd depth stream; sits directly downstream of the radial confidence/z masking stage. Pixels that stage rejected (fp16 word exactly 16'h7FFF) are replaced with the last accepted value on the same row, for at most MAX_RUN consecutive pixels. Per-frame counts of filled and unfillable pixels are also produced. Streaming, no backpressure, one pixel per cycle max.

## Interface
- MAX_RUN, 8: max consecutive masked pixels filled from one held value (1..255)
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- data_i  in  16  fp16 depth, 16'h7FFF = masked
- confidence_i  in  16  fp16 confidence, passed through
- col_i, row_i  in  16 each  pixel coordinates, unsigned
- valid_i  in  1  pixel qualifier
- image_width_i, image_height_i  in  16 each  frame size; quasi-static, changed only between frames
- data_o  out  16  filled or passed-through depth
- confidence_o, col_o, row_o  out  16 each  registered copies of inputs
- valid_o  out  1  output qualifier
- filled_count_o  out  32  masked pixels filled in last completed frame
- dropped_count_o  out  32  masked pixels left masked in last completed frame
- stats_valid_o  out  1  one-cycle pulse when counts update

## Operation
- Masked test: data_i == 16'h7FFF exact compare; every other value (other NaNs, infinities included) is a valid sample.
- Fill FSM, advanced only on valid_i:
  - NO_REF: valid sample -> load ref, run=0, go REF; masked -> output 16'h7FFF, dropped++.
  - REF: valid sample -> load ref, run=0; masked with run < MAX_RUN -> output ref, run++, filled++; masked with run == MAX_RUN -> output 16'h7FFF, dropped++, go EXHAUSTED.
  - EXHAUSTED: valid sample -> load ref, run=0, go REF; masked -> output 16'h7FFF, dropped++.
- Row start: valid_i with col_i == 0 forces NO_REF before evaluating that pixel, so col 0 is never filled from the previous row.
- Frame end: valid_i with col_i == image_width_i-1 and row_i == image_height_i-1. That pixel's contribution is included. Totals are copied to the outputs, stats_valid_o pulses, and the accumulators restart at 0. FSM goes NO_REF.
- Accumulators saturate at 32'hFFFF_FFFF; no wrap.
- run is $clog2(MAX_RUN+1) bits wide, never exceeds MAX_RUN.
- Pixels with valid_i low: no state, ref, or counter change; data/col/row/confidence still registered to outputs.

## Timing
- Latency 1 cycle on all stream outputs (data, confidence, col, row, valid), aligned.
- filled_count_o/dropped_count_o/stats_valid_o update in the same cycle valid_o presents the frame-end pixel.
- Counts hold until the next frame end.
- Reset (async assert, sync deassert in the surrounding design):
  - All outputs 0; FSM NO_REF; ref 0; run 0; accumulators 0.
  - Reset mid-frame discards partial counts; no stats pulse is issued for that frame.
- Back-to-back frames (frame end followed immediately by col 0 row 0): the first pixel of the new frame counts into fresh accumulators.

## Structure
- Shared dfdd_pkg constants and types:
  - FP16_MASKED = 16'h7FFF, shared with the masking stage.
  - fill_state_t enum {NO_REF, REF, EXHAUSTED}.
- One sub-module: sat_counter32 (inc, clear-and-restart, saturating), instantiated twice.

## Test plan
- Row [1.0, 7FFF, 7FFF, 2.0], MAX_RUN=8 -> data_o [3C00, 3C00, 3C00, 4000]; filled +2.
- MAX_RUN=2, row [3C00, 7FFF×4, 4000] -> [3C00, 3C00, 3C00, 7FFF, 7FFF, 4000]; filled 2, dropped 2.
- Row 0 ends 3C00, row 1 col 0 = 7FFF -> data_o 7FFF; dropped +1.
- 4×2 frame, all valid, 3 masked fillable + 1 at col 0 -> single stats_valid_o pulse on the last pixel's output cycle with filled=3, dropped=1; the next frame starts at 0.
- valid_i gaps inside a masked run -> the run count is unaffected by idle cycles; same output as the gapless stream.
- rst_i asserted mid-frame -> all outputs 0 immediately; the next full frame reports only its own counts.

Source files
------------

// File: rtl/dfdd_pkg.sv
// Shared dfdd depth-stream constants and types.
// Also holds the saturating increment used by the statistics counters.
package dfdd_pkg;

   localparam logic [15:0] FP16_MASKED = 16'h7FFF;

   typedef enum logic [1:0] {
      NO_REF,
      REF,
      EXHAUSTED
   } fill_state_t;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic        inc
   );
      return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit saturating event counter with clear-and-restart.
// o_total already includes the current increment, so it is the frame total.
module sat_counter32
   import dfdd_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_inc,
   input  logic        i_clr,
   output logic [31:0] o_total
);

   logic [31:0] r_cnt;

   assign o_total = sat_inc(r_cnt, i_inc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= o_total;
      end
   end

endmodule

// File: rtl/masked_fill_fp16.sv
// Row-wise hole filler for the dfdd depth stream.
// Masked pixels take the last accepted row value for up to MAX_RUN pixels.
module masked_fill_fp16
   import dfdd_pkg::*;
#(
   parameter int unsigned MAX_RUN = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] data_i,
   input  logic [15:0] confidence_i,
   input  logic [15:0] col_i,
   input  logic [15:0] row_i,
   input  logic        valid_i,
   input  logic [15:0] image_width_i,
   input  logic [15:0] image_height_i,
   output logic [15:0] data_o,
   output logic [15:0] confidence_o,
   output logic [15:0] col_o,
   output logic [15:0] row_o,
   output logic        valid_o,
   output logic [31:0] filled_count_o,
   output logic [31:0] dropped_count_o,
   output logic        stats_valid_o
);

   localparam int RW = $clog2(MAX_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RUN);

   fill_state_t   r_state;
   fill_state_t   w_state_eff;
   fill_state_t   w_state_nxt;
   logic [15:0]   r_ref;
   logic [15:0]   w_ref_nxt;
   logic [15:0]   w_data;
   logic [RW-1:0] r_run;
   logic [RW-1:0] w_run_nxt;
   logic          w_masked;
   logic          w_inc_f;
   logic          w_inc_d;
   logic          w_frame_end;
   logic [31:0]   w_filled_tot;
   logic [31:0]   w_dropped_tot;

   assign w_masked = (data_i == FP16_MASKED);

   assign w_frame_end = valid_i
      && (col_i == image_width_i - 16'd1)
      && (row_i == image_height_i - 16'd1);

   // Column 0 never inherits a reference from the previous row.
   always_comb begin
      w_state_eff = (col_i == 16'd0) ? NO_REF : r_state;
      w_state_nxt = w_state_eff;
      w_ref_nxt   = r_ref;
      w_run_nxt   = r_run;
      w_data      = data_i;
      w_inc_f     = 1'b0;
      w_inc_d     = 1'b0;
      if (!w_masked) begin
         w_state_nxt = REF;
         w_ref_nxt   = data_i;
         w_run_nxt   = '0;
      end else if (w_state_eff == REF && r_run < RUN_MAX) begin
         w_data    = r_ref;
         w_run_nxt = r_run + 1'b1;
         w_inc_f   = 1'b1;
      end else begin
         w_data  = FP16_MASKED;
         w_inc_d = 1'b1;
         if (w_state_eff == REF) begin
            w_state_nxt = EXHAUSTED;
         end
      end
   end

   sat_counter32 u_filled (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (valid_i & w_inc_f),
      .i_clr   (w_frame_end),
      .o_total (w_filled_tot)
   );

   sat_counter32 u_dropped (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (valid_i & w_inc_d),
      .i_clr   (w_frame_end),
      .o_total (w_dropped_tot)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state         <= NO_REF;
         r_ref           <= '0;
         r_run           <= '0;
         data_o          <= '0;
         confidence_o    <= '0;
         col_o           <= '0;
         row_o           <= '0;
         valid_o         <= 1'b0;
         filled_count_o  <= '0;
         dropped_count_o <= '0;
         stats_valid_o   <= 1'b0;
      end else begin
         data_o        <= valid_i ? w_data : data_i;
         confidence_o  <= confidence_i;
         col_o         <= col_i;
         row_o         <= row_i;
         valid_o       <= valid_i;
         stats_valid_o <= w_frame_end;
         if (valid_i) begin
            r_state <= w_frame_end ? NO_REF : w_state_nxt;
            r_ref   <= w_ref_nxt;
            r_run   <= w_run_nxt;
         end
         if (w_frame_end) begin
            filled_count_o  <= w_filled_tot;
            dropped_count_o <= w_dropped_tot;
         end
      end
   end

endmodule

// File: tb/tb_masked_fill_fp16.sv
// Randomised and directed bench for masked_fill_fp16 (MAX_RUN 8 and 2).
// A row-level fill model predicts every output cycle.
module tb_masked_fill_fp16;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic [15:0] data_i = '0;
   logic [15:0] conf_i = '0;
   logic [15:0] col_i = '0;
   logic [15:0] row_i = '0;
   logic        valid_i = 1'b0;
   logic [15:0] width_i = 16'd4;
   logic [15:0] height_i = 16'd1;

   logic [15:0] a_data, a_conf, a_col, a_row;
   logic        a_valid, a_sv;
   logic [31:0] a_fc, a_dc;
   logic [15:0] b_data, b_conf, b_col, b_row;
   logic        b_valid, b_sv;
   logic [31:0] b_fc, b_dc;

   int comps = 0;
   int fails = 0;

   int          mr [2] = '{8, 2};
   bit          have_ref [2];
   logic [15:0] last [2];
   int          msince [2];
   longint      accf [2];
   longint      accd [2];
   logic [15:0] e_data [2];
   logic [31:0] e_fc [2];
   logic [31:0] e_dc [2];
   logic        e_sv [2];
   logic [15:0] e_conf, e_col, e_row;
   logic        e_valid;

   always #5 clk = ~clk;

   masked_fill_fp16 #(.MAX_RUN(8)) u_a (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i),
      .confidence_i(conf_i), .col_i(col_i), .row_i(row_i),
      .valid_i(valid_i), .image_width_i(width_i),
      .image_height_i(height_i), .data_o(a_data),
      .confidence_o(a_conf), .col_o(a_col), .row_o(a_row),
      .valid_o(a_valid), .filled_count_o(a_fc),
      .dropped_count_o(a_dc), .stats_valid_o(a_sv)
   );

   masked_fill_fp16 #(.MAX_RUN(2)) u_b (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i),
      .confidence_i(conf_i), .col_i(col_i), .row_i(row_i),
      .valid_i(valid_i), .image_width_i(width_i),
      .image_height_i(height_i), .data_o(b_data),
      .confidence_o(b_conf), .col_o(b_col), .row_o(b_row),
      .valid_o(b_valid), .filled_count_o(b_fc),
      .dropped_count_o(b_dc), .stats_valid_o(b_sv)
   );

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         have_ref[k] = 0; last[k] = '0; msince[k] = 0;
         accf[k] = 0; accd[k] = 0;
         e_data[k] = '0; e_fc[k] = '0; e_dc[k] = '0; e_sv[k] = 1'b0;
      end
      e_conf = '0; e_col = '0; e_row = '0; e_valid = 1'b0;
   endtask

   // A masked pixel is filled when the row has an accepted sample and
   // at most MAX_RUN masked pixels (this one included) follow it.
   task automatic step(input bit v, input logic [15:0] d,
                       input logic [15:0] c, input logic [15:0] r);
      bit fe;
      valid_i = v; data_i = d; col_i = c; row_i = r;
      conf_i = 16'($urandom);
      fe = v && (c == width_i - 16'd1) && (r == height_i - 16'd1);
      for (int k = 0; k < 2; k++) begin
         e_sv[k] = 1'b0;
         if (!v) begin
            e_data[k] = d;
         end else begin
            if (c == 16'd0) have_ref[k] = 0;
            if (d != 16'h7FFF) begin
               have_ref[k] = 1; last[k] = d; msince[k] = 0;
               e_data[k] = d;
            end else if (have_ref[k] && msince[k] < mr[k]) begin
               msince[k]++; e_data[k] = last[k]; accf[k]++;
            end else begin
               msince[k]++; e_data[k] = 16'h7FFF; accd[k]++;
            end
            if (fe) begin
               e_fc[k] = (accf[k] > 64'hFFFF_FFFF) ? '1 : 32'(accf[k]);
               e_dc[k] = (accd[k] > 64'hFFFF_FFFF) ? '1 : 32'(accd[k]);
               e_sv[k] = 1'b1;
               accf[k] = 0; accd[k] = 0; have_ref[k] = 0;
            end
         end
      end
      e_conf = conf_i; e_col = c; e_row = r; e_valid = v;
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst_i = 1'b0; valid_i = 1'b0; data_i = '0;
      col_i = '0; row_i = '0; conf_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      if ({a_data, a_conf, a_col, a_row, a_valid, a_fc, a_dc, a_sv,
           b_data, b_conf, b_col, b_row, b_valid, b_fc, b_dc, b_sv} !== '0) begin
         fails++;
         $display("FAIL reset: got a=%h/%h/%0d b=%h/%h/%0d want all 0",
                  a_data, a_fc, a_sv, b_data, b_fc, b_sv);
      end
      comps++;
   endtask

   task automatic test_row_fill();
      logic [15:0] px [4] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h4000};
      logic [15:0] ex [4] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
      width_i = 16'd4; height_i = 16'd1;
      for (int i = 0; i < 4; i++) begin
         step(1, px[i], 16'(i), 16'd0);
         if ({a_data, b_data} !== {ex[i], e_data[1]}) begin
            fails++;
            $display("FAIL row_fill px%0d: got %h/%h want %h/%h",
                     i, a_data, b_data, ex[i], e_data[1]);
         end
         comps++;
      end
      if ({a_sv, a_fc, a_dc} !== {1'b1, 32'd2, 32'd0}) begin
         fails++;
         $display("FAIL row_fill stats: got %0d/%0d/%0d want 1/2/0",
                  a_sv, a_fc, a_dc);
      end
      comps++;
   endtask

   task automatic test_max_run();
      logic [15:0] px [6] = '{16'h3C00, 16'h7FFF, 16'h7FFF,
                              16'h7FFF, 16'h7FFF, 16'h4000};
      logic [15:0] ex [6] = '{16'h3C00, 16'h3C00, 16'h3C00,
                              16'h7FFF, 16'h7FFF, 16'h4000};
      width_i = 16'd6; height_i = 16'd1;
      for (int i = 0; i < 6; i++) begin
         step(1, px[i], 16'(i), 16'd0);
         if ({a_data, b_data} !== {e_data[0], ex[i]}) begin
            fails++;
            $display("FAIL max_run px%0d: got %h/%h want %h/%h",
                     i, a_data, b_data, e_data[0], ex[i]);
         end
         comps++;
      end
      if ({b_sv, b_fc, b_dc, a_fc, a_dc} !==
          {1'b1, 32'd2, 32'd2, 32'd4, 32'd0}) begin
         fails++;
         $display("FAIL max_run stats: got b=%0d/%0d a=%0d/%0d want 2/2 4/0",
                  b_fc, b_dc, a_fc, a_dc);
      end
      comps++;
   endtask

   task automatic test_row_boundary();
      logic [15:0] px [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h3C00,
                              16'h7FFF, 16'h4000, 16'h4000, 16'h4000};
      width_i = 16'd4; height_i = 16'd2;
      for (int i = 0; i < 8; i++) begin
         step(1, px[i], 16'(i % 4), 16'(i / 4));
         if ({a_data, b_data} !== {e_data[0], e_data[1]}) begin
            fails++;
            $display("FAIL row_boundary px%0d: got %h/%h want %h/%h",
                     i, a_data, b_data, e_data[0], e_data[1]);
         end
         comps++;
         if (i == 4 && a_data !== 16'h7FFF) begin
            fails++;
            $display("FAIL row_boundary col0: got %h want 7fff", a_data);
         end
         if (i == 4) comps++;
      end
      if ({a_sv, a_fc, a_dc} !== {1'b1, 32'd0, 32'd1}) begin
         fails++;
         $display("FAIL row_boundary stats: got %0d/%0d/%0d want 1/0/1",
                  a_sv, a_fc, a_dc);
      end
      comps++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] px [16] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h4000,
                               16'h7FFF, 16'h4200, 16'h7FFF, 16'h4400,
                               16'h1234, 16'h2345, 16'h3456, 16'h4567,
                               16'h7FFE, 16'hFFFF, 16'h7C00, 16'h0000};
      width_i = 16'd4; height_i = 16'd2;
      for (int i = 0; i < 16; i++) begin
         step(1, px[i], 16'(i % 4), 16'((i / 4) % 2));
         if ({a_sv, a_fc, a_dc, b_sv, b_fc, b_dc} !==
             {e_sv[0], e_fc[0], e_dc[0], e_sv[1], e_fc[1], e_dc[1]}) begin
            fails++;
            $display("FAIL back_to_back stats px%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                     i, a_sv, a_fc, a_dc, e_sv[0], e_fc[0], e_dc[0]);
         end
         comps++;
         if (i == 7 && {a_sv, a_fc, a_dc} !== {1'b1, 32'd3, 32'd1}) begin
            fails++;
            $display("FAIL back_to_back frame1: got %0d/%0d/%0d want 1/3/1",
                     a_sv, a_fc, a_dc);
         end
         if (i == 15 && {a_sv, a_fc, a_dc} !== {1'b1, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL back_to_back frame2: got %0d/%0d/%0d want 1/0/0",
                     a_sv, a_fc, a_dc);
         end
         if (i == 7 || i == 15) comps++;
      end
   endtask

   task automatic test_gaps();
      logic [15:0] px [4] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h4000};
      logic [15:0] ex [4] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
      width_i = 16'd4; height_i = 16'd1;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(1, 3))
            step(0, 16'h7FFF, 16'($urandom), 16'($urandom));
         step(1, px[i], 16'(i), 16'd0);
         if ({a_data, b_data} !== {ex[i], ex[i]}) begin
            fails++;
            $display("FAIL gaps px%0d: got %h/%h want %h",
                     i, a_data, b_data, ex[i]);
         end
         comps++;
      end
      if ({b_sv, b_fc, b_dc} !== {1'b1, 32'd2, 32'd0}) begin
         fails++;
         $display("FAIL gaps stats: got %0d/%0d/%0d want 1/2/0",
                  b_sv, b_fc, b_dc);
      end
      comps++;
   endtask

   task automatic test_reset_midframe();
      logic [15:0] px [8] = '{16'h3C00, 16'h7FFF, 16'h4000, 16'h4000,
                              16'h4000, 16'h4000, 16'h4000, 16'h4000};
      width_i = 16'd4; height_i = 16'd2;
      for (int i = 0; i < 5; i++)
         step(1, (i % 2 == 1) ? 16'h7FFF : 16'h3C00, 16'(i % 4), 16'(i / 4));
      #2 rst_i = 1'b0;
      #1;
      if ({a_data, a_conf, a_col, a_row, a_valid, a_fc, a_dc, a_sv,
           b_data, b_conf, b_col, b_row, b_valid, b_fc, b_dc, b_sv} !== '0) begin
         fails++;
         $display("FAIL reset_midframe: got a=%h/%h/%0d want all 0",
                  a_data, a_col, a_valid);
      end
      comps++;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, px[i], 16'(i % 4), 16'(i / 4));
         if ({a_sv, a_fc, a_dc, b_sv, b_fc, b_dc} !==
             {e_sv[0], e_fc[0], e_dc[0], e_sv[1], e_fc[1], e_dc[1]}) begin
            fails++;
            $display("FAIL reset_midframe stats px%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                     i, a_sv, a_fc, a_dc, e_sv[0], e_fc[0], e_dc[0]);
         end
         comps++;
      end
      if ({a_fc, a_dc} !== {32'd1, 32'd0}) begin
         fails++;
         $display("FAIL reset_midframe frame: got %0d/%0d want 1/0", a_fc, a_dc);
      end
      comps++;
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [15:0] sp [4] = '{16'h7FFE, 16'hFFFF, 16'h7C00, 16'hFC00};
      width_i = 16'd5; height_i = 16'd3;
      for (int f = 0; f < 30; f++) begin
         for (int p = 0; p < 15; p++) begin
            while ($urandom_range(0, 3) == 0)
               step(0, 16'($urandom), 16'($urandom), 16'($urandom));
            case ($urandom_range(0, 5))
               0, 1, 2: d = 16'h7FFF;
               3:       d = sp[$urandom_range(0, 3)];
               default: d = 16'($urandom);
            endcase
            step(1, d, 16'(p % 5), 16'(p / 5));
            if ({a_data, b_data} !== {e_data[0], e_data[1]}) begin
               fails++;
               $display("FAIL random data f%0d p%0d: got %h/%h want %h/%h",
                        f, p, a_data, b_data, e_data[0], e_data[1]);
            end
            comps++;
            if ({a_conf, a_col, a_row, a_valid, b_conf, b_col, b_row, b_valid} !==
                {e_conf, e_col, e_row, e_valid, e_conf, e_col, e_row, e_valid}) begin
               fails++;
               $display("FAIL random pass f%0d p%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d",
                        f, p, a_conf, a_col, a_row, a_valid,
                        e_conf, e_col, e_row, e_valid);
            end
            comps++;
            if ({a_sv, a_fc, a_dc, b_sv, b_fc, b_dc} !==
                {e_sv[0], e_fc[0], e_dc[0], e_sv[1], e_fc[1], e_dc[1]}) begin
               fails++;
               $display("FAIL random stats f%0d p%0d: got %0d/%0d/%0d %0d/%0d/%0d want %0d/%0d/%0d %0d/%0d/%0d",
                        f, p, a_sv, a_fc, a_dc, b_sv, b_fc, b_dc,
                        e_sv[0], e_fc[0], e_dc[0], e_sv[1], e_fc[1], e_dc[1]);
            end
            comps++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_row_fill();
      test_max_run();
      test_row_boundary();
      test_back_to_back();
      test_gaps();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end

endmodule
